alu_uart_host: RTL
==================

# alu_uart_host

Synthesizable UART host that drives the ALU-over-UART link from the far end. On a start request it serializes operand A, operand B and the opcode as three 8N1 frames on its serial output, then receives the one-byte result frame returned by the ALU board and presents it with a valid pulse. It sits on the host side of the serial pair, either in a companion FPGA or as a synthesizable stimulus/checker in system simulation. It is the counterpart of the board-side receive/interface path.

## Interface
- LIMITE, 163: baud divider period in clocks; one tick every LIMITE clocks (50 MHz / 19200 baud / 16).
- NB_CONTA, 8: width of the baud divider counter; must satisfy 2^NB_CONTA > LIMITE.
- N_BITS, 8: data bits per frame.
- N_TICKS, 16: ticks per bit.
- N_BITS_OP, 6: opcode width; opcode frame payload is {(N_BITS-N_BITS_OP) zeros, op}.
- GAP_BITS, 1: idle-high bit periods inserted after each transmitted stop bit.
- TIMEOUT_BITS, 30: bit periods allowed for the response start bit before timing out.
- i_clock  in  1  system clock (50 MHz).
- i_reset  in  1  reset; asynchronous, active-high.
- i_start  in  1  request a transaction; accepted only when o_busy=0.
- i_data_a  in  N_BITS  operand A, latched on acceptance.
- i_data_b  in  N_BITS  operand B, latched on acceptance.
- i_op  in  N_BITS_OP  ALU opcode (ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111), latched on acceptance.
- i_rx  in  1  serial input from the ALU board; asynchronous, idle high.
- o_tx  out  1  serial output to the ALU board; idle high.
- o_busy  out  1  transaction in progress.
- o_result  out  N_BITS  last good received result.
- o_result_valid  out  1  one-cycle pulse when o_result updates.
- o_timeout  out  1  one-cycle pulse when no response start bit arrives in time.
- o_frame_err  out  1  one-cycle pulse when the response stop bit samples low.

## Operation
- Reset values: o_tx=1, o_busy=0, o_result=0, o_result_valid=0, o_timeout=0, o_frame_err=0. The FSM returns to IDLE and the divider is cleared. Reset in the middle of a frame forces o_tx high immediately.
- i_rx passes through a 2-flop synchronizer before any use.
- Baud divider: counter runs 0..LIMITE-1 and wraps. The tick is high for one clock when the count equals LIMITE-1. The counter restarts from 0 on an accepted i_start, so transmitted bits are exactly N_TICKS*LIMITE clocks long.
- FSM states: IDLE, TX_START, TX_DATA, TX_STOP, TX_GAP, RX_WAIT, RX_START, RX_DATA, RX_STOP.
- IDLE: on i_start=1, latch the operands, load the frame index to 0, and go to TX_START.
- TX_START: o_tx=0 for N_TICKS ticks, then go to TX_DATA.
- TX_DATA: send N_BITS bits LSB first, N_TICKS ticks each, then go to TX_STOP.
- TX_STOP: o_tx=1 for N_TICKS ticks, then go to TX_GAP.
- TX_GAP: o_tx=1 for GAP_BITS*N_TICKS ticks. If GAP_BITS=0, this state is skipped. The frame index then increments. Frames 0, 1 and 2 are A, B and op; after frame 2, go to RX_WAIT.
- RX_WAIT: clear the tick counter. While synchronized i_rx=1, count ticks; every N_TICKS ticks is one bit period.
  - After TIMEOUT_BITS bit periods, pulse o_timeout and go to IDLE.
  - When i_rx=0, go to RX_START.
- RX_START: at tick N_TICKS/2-1, check the line.
  - If still low, reset the tick count and go to RX_DATA.
  - If high, treat it as a glitch and return to RX_WAIT. The timeout count is kept, not reset.
- RX_DATA: sample at each N_TICKS-th tick, N_BITS samples, shifting right (LSB first), then go to RX_STOP.
- RX_STOP: sample after N_TICKS ticks.
  - Sample 1: load o_result and pulse o_result_valid.
  - Sample 0: pulse o_frame_err; o_result is unchanged.
  - Either way, go to IDLE.
- i_start while o_busy=1 is ignored; no queueing.
- Operand inputs may change freely after acceptance.

## Timing
- Acceptance edge N: o_busy=1 and o_tx=0 from cycle N+1.
- Each transmitted bit lasts N_TICKS*LIMITE = 2608 clocks (52160 ns at 50 MHz).
- One transmitted frame plus gap is (10+GAP_BITS)*2608 clocks. All three frames plus gaps take 3*(10+GAP_BITS)*2608 clocks, i.e. 86064 clocks at the defaults.
- Completion pulses (o_result_valid, o_timeout, o_frame_err) are mutually exclusive and last exactly one cycle. o_busy falls on the same edge as the pulse.
- A new i_start is accepted no earlier than the cycle after o_busy falls.
- Response start-detect latency: 2 synchronizer clocks plus up to 1 tick of quantization. The data sample point lands within ±1 tick of mid-bit.

## Test plan
- Reset: hold i_reset 80 ns. Check o_tx=1 and all other outputs 0. Toggle i_start during reset: no activity.
- Transmit: A=0x55, B=0x57, op=AND (100100). o_tx must carry frames 0x55, 0x57, 0x24, LSB first, each bit 2608 clocks, 1 stop plus 1 gap bit. o_busy must be high throughout.
- Good response: the bench returns an 8N1 frame 0x55 two bit periods after the last gap. Expect o_result=0x55 and one o_result_valid pulse; o_busy must fall on the same edge. Repeat with A=0xFF, B=0x01, op=ADD and response 0x00.
- Timeout: no response. o_timeout pulses exactly 30 bit periods (78240 clocks, ±1 tick) after RX_WAIT entry. o_result must stay at its previous value.
- Error paths:
  - Response frame 0xA5 with stop bit low: o_frame_err pulses, no o_result_valid, o_result unchanged.
  - A 20-clock low glitch on i_rx during RX_WAIT is ignored; a later valid frame is still received.
- Robustness:
  - i_start pulsed mid-transmission is ignored; the o_tx waveform is unchanged.
  - Async reset asserted mid-frame B forces o_tx=1 and o_busy=0. A fresh transaction after reset completes normally.

Source files
------------

// File: rtl/alu_uart_host.sv
// ---------------------------------------------------------------------------
// alu_uart_host
//
// Host side of the ALU-over-UART link. On a start request it sends operand A,
// operand B and the opcode as three 8N1 frames, each followed by a short
// idle-high gap. It then waits for the single result frame from the ALU board
// and reports one of three outcomes as a one-cycle pulse: a good result, a
// timeout (no start bit arrived), or a framing error (stop bit sampled low).
//
// Ports
//   i_clock         system clock
//   i_reset         asynchronous, active-high reset
//   i_start         transaction request, honoured only while o_busy is low
//   i_data_a        operand A, captured when the request is accepted
//   i_data_b        operand B, captured when the request is accepted
//   i_op            ALU opcode, captured when the request is accepted
//   i_rx            serial line from the ALU board (asynchronous, idle high)
//   o_tx            serial line to the ALU board (idle high)
//   o_busy          a transaction is in progress
//   o_result        most recent good result byte
//   o_result_valid  one-cycle pulse when o_result is updated
//   o_timeout       one-cycle pulse when no response start bit arrived in time
//   o_frame_err     one-cycle pulse when the response stop bit was low
// ---------------------------------------------------------------------------
module alu_uart_host #(
   parameter int LIMITE       = 163,
   parameter int NB_CONTA     = 8,
   parameter int N_BITS       = 8,
   parameter int N_TICKS      = 16,
   parameter int N_BITS_OP    = 6,
   parameter int GAP_BITS     = 1,
   parameter int TIMEOUT_BITS = 30
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic [N_BITS-1:0]    i_data_a,
   input  logic [N_BITS-1:0]    i_data_b,
   input  logic [N_BITS_OP-1:0] i_op,
   input  logic                 i_rx,
   output logic                 o_tx,
   output logic                 o_busy,
   output logic [N_BITS-1:0]    o_result,
   output logic                 o_result_valid,
   output logic                 o_timeout,
   output logic                 o_frame_err
);

   // Counter widths. The bit counter is shared by the data bits and the gap
   // bit periods, so it is sized for whichever of the two is longer.
   localparam int TICK_W  = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
   localparam int BIT_MAX = (GAP_BITS > N_BITS) ? GAP_BITS : N_BITS;
   localparam int BIT_W   = $clog2(BIT_MAX + 1);
   localparam int WAIT_W  = $clog2(TIMEOUT_BITS + 1);

   localparam logic [NB_CONTA-1:0] DIV_LAST  = NB_CONTA'(LIMITE - 1);
   localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(N_TICKS - 1);
   localparam logic [TICK_W-1:0]   TICK_MID  = TICK_W'(N_TICKS / 2 - 1);
   localparam logic [BIT_W-1:0]    DATA_LAST = BIT_W'(N_BITS - 1);
   localparam logic [BIT_W-1:0]    GAP_LAST  = BIT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
   localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(TIMEOUT_BITS - 1);

   typedef enum logic [3:0] {
      IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      TX_GAP,
      RX_WAIT,
      RX_START,
      RX_DATA,
      RX_STOP
   } state_t;

   state_t state;
   state_t state_next;

   logic                 rx_meta;
   logic                 rx_sync;
   logic [NB_CONTA-1:0]  div_cnt;
   logic                 tick;
   logic                 tick_last;
   logic [TICK_W-1:0]    tick_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [1:0]           frame_idx;
   logic [WAIT_W-1:0]    wait_cnt;
   logic [N_BITS-1:0]    tx_shift;
   logic [N_BITS-1:0]    rx_shift;
   logic [N_BITS-1:0]    b_reg;
   logic [N_BITS_OP-1:0] op_reg;

   logic accept;
   logic tx_shift_en;
   logic bit_inc;
   logic frame_end;
   logic frame_adv;
   logic rx_sample;
   logic wait_clr;
   logic wait_inc;
   logic valid_next;
   logic timeout_next;
   logic ferr_next;
   logic tx_next;

   // Two-flop synchronizer for the incoming serial line. Both flops reset to
   // the idle level so a reset never looks like a start bit.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_sync <= rx_meta;
      end
   end

   // Baud divider producing one tick every LIMITE clocks. It is restarted when
   // a request is accepted so every transmitted bit has an exact length
   // measured from the acceptance edge.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         div_cnt <= '0;
      end else if (accept || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + NB_CONTA'(1);
      end
   end

   assign tick      = (div_cnt == DIV_LAST);
   assign tick_last = tick && (tick_cnt == TICK_LAST);

   // FSM state register.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic plus the control strobes for the datapath. A frame ends
   // either after the gap or, with no gap configured, right after the stop
   // bit; the frame index then decides between the next frame and listening
   // for the response. In RX_WAIT a low line wins over an expiring timeout.
   // The serial output is computed from the next state so it can be
   // registered and still change on the same edge as the state.
   always_comb begin
      state_next   = state;
      accept       = 1'b0;
      tx_shift_en  = 1'b0;
      bit_inc      = 1'b0;
      frame_end    = 1'b0;
      frame_adv    = 1'b0;
      rx_sample    = 1'b0;
      wait_clr     = 1'b0;
      wait_inc     = 1'b0;
      valid_next   = 1'b0;
      timeout_next = 1'b0;
      ferr_next    = 1'b0;
      tx_next      = 1'b1;

      case (state)
         IDLE: begin
            if (i_start) begin
               accept     = 1'b1;
               state_next = TX_START;
            end
         end
         TX_START: begin
            if (tick_last) begin
               state_next = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tick_last) begin
               tx_shift_en = 1'b1;
               bit_inc     = 1'b1;
               if (bit_cnt == DATA_LAST) begin
                  state_next = TX_STOP;
               end
            end
         end
         TX_STOP: begin
            if (tick_last) begin
               if (GAP_BITS > 0) begin
                  state_next = TX_GAP;
               end else begin
                  frame_end = 1'b1;
               end
            end
         end
         TX_GAP: begin
            if (tick_last) begin
               bit_inc = 1'b1;
               if (bit_cnt == GAP_LAST) begin
                  frame_end = 1'b1;
               end
            end
         end
         RX_WAIT: begin
            if (!rx_sync) begin
               state_next = RX_START;
            end else if (tick_last) begin
               wait_inc = 1'b1;
               if (wait_cnt == WAIT_LAST) begin
                  timeout_next = 1'b1;
                  state_next   = IDLE;
               end
            end
         end
         RX_START: begin
            if (tick && (tick_cnt == TICK_MID)) begin
               state_next = rx_sync ? RX_WAIT : RX_DATA;
            end
         end
         RX_DATA: begin
            if (tick_last) begin
               rx_sample = 1'b1;
               bit_inc   = 1'b1;
               if (bit_cnt == DATA_LAST) begin
                  state_next = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            if (tick_last) begin
               state_next = IDLE;
               if (rx_sync) begin
                  valid_next = 1'b1;
               end else begin
                  ferr_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (frame_end) begin
         if (frame_idx == 2'd2) begin
            state_next = RX_WAIT;
            wait_clr   = 1'b1;
         end else begin
            state_next = TX_START;
            frame_adv  = 1'b1;
         end
      end

      case (state_next)
         TX_START: tx_next = 1'b0;
         TX_DATA:  tx_next = tx_shift_en ? tx_shift[1] : tx_shift[0];
         default:  tx_next = 1'b1;
      endcase
   end

   // Datapath. Tick and bit counters restart on every state change, which
   // gives RX_WAIT a fresh bit period on entry and lines RX_START up with the
   // falling edge. The timeout counter is only cleared when leaving the
   // transmit side, so a rejected glitch does not extend the timeout.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         o_tx           <= 1'b1;
         tick_cnt       <= '0;
         bit_cnt        <= '0;
         frame_idx      <= '0;
         wait_cnt       <= '0;
         tx_shift       <= '0;
         rx_shift       <= '0;
         b_reg          <= '0;
         op_reg         <= '0;
         o_result       <= '0;
         o_result_valid <= 1'b0;
         o_timeout      <= 1'b0;
         o_frame_err    <= 1'b0;
      end else begin
         o_tx           <= tx_next;
         o_result_valid <= valid_next;
         o_timeout      <= timeout_next;
         o_frame_err    <= ferr_next;

         if (state_next != state) begin
            tick_cnt <= '0;
         end else if (tick) begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
         end

         if (state_next != state) begin
            bit_cnt <= '0;
         end else if (bit_inc) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
         end

         if (accept) begin
            frame_idx <= '0;
            tx_shift  <= i_data_a;
            b_reg     <= i_data_b;
            op_reg    <= i_op;
         end else if (frame_adv) begin
            frame_idx <= frame_idx + 2'd1;
            tx_shift  <= (frame_idx == 2'd0) ? b_reg : N_BITS'(op_reg);
         end else if (tx_shift_en) begin
            tx_shift <= tx_shift >> 1;
         end

         if (wait_clr) begin
            wait_cnt <= '0;
         end else if (wait_inc) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end

         if (rx_sample) begin
            rx_shift <= {rx_sync, rx_shift[N_BITS-1:1]};
         end

         if (valid_next) begin
            o_result <= rx_shift;
         end
      end
   end

   assign o_busy = (state != IDLE);

endmodule
